// File: rtl/psimd_fetch_pkg.sv
// Shared types and constants for the PSIMD instruction fetch queue.
// Contents:
//   XLEN_DEF / MEM_DEPTH_DEF / PC_W_DEF : default geometry
//   ST_* constants and fetch_state_t     : fetch sequencer states
//   fetch_entry_t                        : queue entry layout {instr, pc} at default geometry
//   in_run_state()                       : true while the sequencer owns the memory
package psimd_fetch_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int MEM_DEPTH_DEF = 64;
    localparam int PC_W_DEF      = $clog2(MEM_DEPTH_DEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [PC_W_DEF-1:0] pc;
    } fetch_entry_t;

    function automatic logic in_run_state(input fetch_state_t s);
        return (s == FETCH) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, used as the fetch output queue.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop all entries (overrides push/pop this cycle)
//   push, push_data   : enqueue (taken when not full, or when popping at the same time)
//   pop, pop_data     : dequeue; pop_data shows the head entry
//   count, empty, full: occupancy status
module sync_fifo
    import psimd_fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty    = (count_r == {(PW+1){1'b0}});
    assign full     = (count_r == (PW+1)'(DEPTH));
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: loadable instruction memory walked by a program
// counter, feeding a small output FIFO drained through a valid/ready port.
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   load_en, load_addr, load_data      : memory write (only while IDLE/DONE)
//   start, prog_len                    : launch at pc=0 for prog_len words (only while IDLE/DONE)
//   redirect_valid, redirect_pc        : jump with flush (only while FETCH/DRAIN)
//   out_valid, out_instr, out_pc, out_ready : instruction output handshake
//   busy, done                         : FETCH/DRAIN and DONE status
module instr_fetch_queue
    import psimd_fetch_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MEM_DEPTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    input  logic            start,
    input  logic [AW:0]     prog_len,
    input  logic            redirect_valid,
    input  logic [AW-1:0]   redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [AW-1:0]   out_pc,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [AW-1:0]   pc;
    } entry_t;

    logic [XLEN-1:0] mem_r [MEM_DEPTH];

    fetch_state_t    state_r;
    fetch_state_t    state_nx_s;
    // One extra bit so pc can reach MEM_DEPTH and stop without wrapping to 0.
    logic [AW:0]     pc_r;
    logic [AW:0]     pc_nx_s;
    logic [AW:0]     pc_inc_s;
    logic [AW:0]     len_r;
    logic            inflight_r;
    logic [XLEN-1:0] rd_data_r;
    logic [AW-1:0]   rd_pc_r;

    logic            idle_like_s;
    logic            start_s;
    logic            load_s;
    logic            redirect_s;
    logic            redir_past_end_s;
    logic [CNTW:0]   occ_s;
    logic            credit_ok_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;

    entry_t          push_entry_s;
    entry_t          head_s;
    logic [CNTW-1:0] fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;

    assign idle_like_s      = (state_r == IDLE) || (state_r == DONE);
    assign start_s          = start && idle_like_s;
    assign load_s           = load_en && idle_like_s;
    assign redirect_s       = redirect_valid && in_run_state(state_r);
    assign redir_past_end_s = ({1'b0, redirect_pc} >= len_r);
    assign pc_inc_s         = pc_r + 1'b1;

    // The read in flight already owns a queue slot, so the queue can never overflow.
    assign occ_s       = {1'b0, fifo_count_s} + {{CNTW{1'b0}}, inflight_r};
    assign credit_ok_s = (occ_s < (CNTW+1)'(FIFO_DEPTH)) && !fifo_full_s;
    assign issue_s     = (state_r == FETCH) && !redirect_s && (pc_r < len_r) && credit_ok_s;

    // A redirect discards the word returning from memory this cycle.
    assign push_s       = inflight_r && !redirect_s;
    assign pop_s        = out_ready && !fifo_empty_s;
    assign push_entry_s = {rd_data_r, rd_pc_r};

    // Sequencer next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_s) begin
                    if (prog_len == {(AW+1){1'b0}}) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            FETCH: begin
                if (redirect_s) begin
                    state_nx_s = redir_past_end_s ? DRAIN : FETCH;
                end else if ((pc_r >= len_r) || (issue_s && (pc_inc_s == len_r))) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_s) begin
                    state_nx_s = redir_past_end_s ? DRAIN : FETCH;
                end else if (fifo_empty_s && !inflight_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Program counter next value: start beats redirect beats sequential issue.
    always_comb begin
        pc_nx_s = pc_r;
        if (start_s) begin
            pc_nx_s = {(AW+1){1'b0}};
        end else if (redirect_s) begin
            pc_nx_s = {1'b0, redirect_pc};
        end else if (issue_s) begin
            pc_nx_s = pc_inc_s;
        end else begin
            pc_nx_s = pc_r;
        end
    end

    // Sequencer state, program counter, length and the one-deep read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= {(AW+1){1'b0}};
            len_r      <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            rd_data_r  <= {XLEN{1'b0}};
            rd_pc_r    <= {AW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            pc_r       <= pc_nx_s;
            inflight_r <= issue_s;
            if (start_s) begin
                len_r <= prog_len;
            end
            if (issue_s) begin
                rd_data_r <= mem_r[pc_r[AW-1:0]];
                rd_pc_r   <= pc_r[AW-1:0];
            end
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            mem_r[load_addr] <= load_data;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_s),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Head fields are masked while empty so idle outputs read as zero.
    assign out_valid = !fifo_empty_s;
    assign out_instr = fifo_empty_s ? {XLEN{1'b0}} : head_s.instr;
    assign out_pc    = fifo_empty_s ? {AW{1'b0}}   : head_s.pc;
    assign busy      = in_run_state(state_r);
    assign done      = (state_r == DONE);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: expected output streams are
// built from a memory image and the program length/redirect rules.
module tb_instr_fetch_queue;

    localparam int XLEN      = 32;
    localparam int MEM_DEPTH = 64;
    localparam int AW        = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [XLEN-1:0] load_data;
    logic            start;
    logic [AW:0]     prog_len;
    logic            redirect_valid;
    logic [AW-1:0]   redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [AW-1:0]   out_pc;
    logic            out_ready;
    logic            busy;
    logic            done;

    typedef struct {
        int          pc;
        logic [31:0] instr;
    } exp_t;

    logic [31:0] model_mem [MEM_DEPTH];
    exp_t        exp_q [$];
    int          cur_len;
    int          n_tests = 0;
    int          n_fail  = 0;

    instr_fetch_queue #(.XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .prog_len       (prog_len),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_exp(input int from, input int len);
        exp_t e;
        exp_q.delete();
        for (int p = from; p < len; p++) begin
            e.pc    = p;
            e.instr = model_mem[p];
            exp_q.push_back(e);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 6'(addr);
        load_data = data;
        model_mem[addr] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic start_prog(input int len, input bit do_load, input int la, input logic [31:0] ld);
        start    = 1'b1;
        prog_len = 7'(len);
        if (do_load) begin
            load_en   = 1'b1;
            load_addr = 6'(la);
            load_data = ld;
            model_mem[la] = ld;
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        cur_len = len;
        build_exp(0, len);
    endtask

    // Runs the handshake until the expected stream is consumed, then checks done timing.
    task automatic drain(input int max_cyc, input int ready_pct, input int stall,
                         input int redir_head, input int redir_tgt, input int exp_n, input bit consec);
        int   cyc = 0;
        int   n = 0;
        int   first_c = -1;
        int   last_c = -1;
        bit   fin = 1'b0;
        bit   redir_done = 1'b0;
        bit   hs;
        exp_t e;
        while (!fin && cyc < max_cyc) begin
            redirect_valid = 1'b0;
            if (cyc < stall) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && !redir_done && redir_head >= 0 && int'(out_pc) == redir_head) begin
                redirect_valid = 1'b1;
                redirect_pc    = 6'(redir_tgt);
                out_ready      = 1'b1;
            end
            hs = out_valid && out_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("head_pc", 64'(out_pc), 64'(e.pc));
                    chk("head_instr", 64'(out_instr), 64'(e.instr));
                    if (hs) begin
                        void'(exp_q.pop_front());
                        n++;
                        if (first_c < 0) first_c = cyc;
                        last_c = cyc;
                    end
                end
            end
            if (redirect_valid) begin
                redir_done = 1'b1;
                build_exp(redir_tgt, cur_len);
            end
            if (hs && exp_q.size() == 0) fin = 1'b1;
            @(negedge clk);
            cyc++;
        end
        redirect_valid = 1'b0;
        chk("xfer_count", 64'(n), 64'(exp_n));
        chk("stream_end_seen", {63'd0, fin}, 64'd1);
        if (fin) begin
            chk("post_valid", {63'd0, out_valid}, 64'd0);
            chk("post_done", {63'd0, done}, 64'd0);
            @(negedge clk);
            chk("end_done", {63'd0, done}, 64'd1);
            chk("end_busy", {63'd0, busy}, 64'd0);
            if (consec) chk("gapless", 64'(last_c - first_c), 64'(exp_n - 1));
        end
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        prog_len = '0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < MEM_DEPTH; k++) load_word(k, $urandom);
        for (int k = 0; k < 8; k++) load_word(k, 32'h100 + 32'(k));

        // Basic stream: 2-cycle latency, back-to-back output, done after drain.
        start_prog(8, 1'b0, 0, 32'd0);
        out_ready = 1'b1;
        chk("lat_c0", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_c2", {63'd0, out_valid}, 64'd1);
        drain(200, 100, 0, -1, 0, 8, 1'b1);

        // Stall with stray load/start while running; both must be ignored.
        start_prog(8, 1'b0, 0, 32'd0);
        out_ready = 1'b0; start = 1'b1; prog_len = 7'd2;
        load_en = 1'b1; load_addr = 6'd7; load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        drain(300, 100, 10, -1, 0, 8, 1'b0);

        // Redirect to 5 with pc 2 at the head and pc 3 in flight.
        start_prog(8, 1'b0, 0, 32'd0);
        drain(200, 100, 0, 2, 5, 6, 1'b0);

        // Redirect beyond program end: nothing more emitted.
        start_prog(8, 1'b0, 0, 32'd0);
        drain(200, 100, 0, 1, 9, 2, 1'b0);

        // Full-memory program under random back-pressure.
        start_prog(MEM_DEPTH, 1'b0, 0, 32'd0);
        drain(3000, 50, 0, -1, 0, MEM_DEPTH, 1'b0);

        // Zero-length program, ignored redirect, then load+start in one cycle.
        start_prog(0, 1'b0, 0, 32'd0);
        chk("len0_done", {63'd0, done}, 64'd1);
        chk("len0_busy", {63'd0, busy}, 64'd0);
        chk("len0_valid", {63'd0, out_valid}, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 6'd1;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_done_ign", {63'd0, done}, 64'd1);
        chk("redir_valid_ign", {63'd0, out_valid}, 64'd0);
        start_prog(3, 1'b1, 1, 32'hCAFE_0001);
        drain(200, 50, 0, -1, 0, 3, 1'b0);

        // Reset with three entries queued; memory must survive.
        start_prog(8, 1'b0, 0, 32'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        start_prog(8, 1'b0, 0, 32'd0);
        drain(300, 70, 0, -1, 0, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
